// File: rtl/bsg_adder_ripple_carry_pipelined.sv
// bsg_adder_ripple_carry_pipelined: segmented ripple-carry add/sub with a registered carry per stage
module bsg_adder_ripple_carry_pipelined #(
  parameter int width_p  = 32,
  parameter int stages_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               c_i,
  input  logic               sub_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] s_o,
  output logic               c_o,
  output logic               ovf_o
);
  localparam int seg_w = width_p / stages_p;
  logic adv;
  assign adv = ~v_o | yumi_i;
  assign ready_o = adv;
  if (stages_p < 1 || width_p % stages_p != 0) begin : g_bad
    $error("width_p must be a positive multiple of stages_p");
  end
  // Stage k owns operand bits from k*seg_w up; consumed low segments are dropped from its registers
  for (genvar k = 0; k < stages_p; k++) begin : st
    localparam int lo  = k * seg_w;
    localparam int opw = width_p - lo;
    logic [opw-1:0] a_in, b_in;
    logic c_in, v_in, v_q, c_q;
    logic [seg_w:0] sum;
    logic [lo+seg_w-1:0] s_q;
    assign sum = {1'b0, a_in[seg_w-1:0]} + {1'b0, b_in[seg_w-1:0]} + {{seg_w{1'b0}}, c_in};
    always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= sum[seg_w];
      end
    if (k == 0) begin : g_src
      assign a_in = a_i;
      assign b_in = sub_i ? ~b_i : b_i;
      assign c_in = c_i ^ sub_i;
      assign v_in = v_i;
      always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) s_q <= '0;
        else if (adv) s_q <= sum[seg_w-1:0];
    end else begin : g_src
      assign a_in = st[k-1].g_op.a_q;
      assign b_in = st[k-1].g_op.b_q;
      assign c_in = st[k-1].c_q;
      assign v_in = st[k-1].v_q;
      always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) s_q <= '0;
        else if (adv) s_q <= {sum[seg_w-1:0], st[k-1].s_q};
    end
    if (k < stages_p - 1) begin : g_op
      logic [opw-seg_w-1:0] a_q, b_q;
      always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[opw-1:seg_w];
          b_q <= b_in[opw-1:seg_w];
        end
    end else begin : g_ovf
      logic ovf_q;
      // a^b^sum at the MSB recovers the carry into the MSB
      always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) ovf_q <= 1'b0;
        else if (adv) ovf_q <= a_in[seg_w-1] ^ b_in[seg_w-1] ^ sum[seg_w-1] ^ sum[seg_w];
    end
  end
  assign v_o   = st[stages_p-1].v_q;
  assign s_o   = st[stages_p-1].s_q;
  assign c_o   = st[stages_p-1].c_q;
  assign ovf_o = st[stages_p-1].g_ovf.ovf_q;
  assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
endmodule

// File: tb/tb_bsg_adder_ripple_carry_pipelined.sv
// tb_bsg_adder_ripple_carry_pipelined: directed checks of the pipelined adder plus a small parameter sweep
module tb_bsg_adder_ripple_carry_pipelined;
  logic clk = 1'b0;
  logic reset_n;
  logic v_i, ready, c_i, sub_i, v_o, yumi, yumi_en, c_o, ovf;
  logic [31:0] a_i, b_i, s_o;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  assign yumi = yumi_en & v_o;

  bsg_adder_ripple_carry_pipelined #(.width_p(32), .stages_p(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .ready_o(ready), .a_i(a_i), .b_i(b_i),
    .c_i(c_i), .sub_i(sub_i), .v_o(v_o), .yumi_i(yumi), .s_o(s_o), .c_o(c_o), .ovf_o(ovf));

  logic [63:0] ra, rb;
  logic rc, rsub, sv;
  logic rdy0, rdy1, rdy2, v0, v1, v2, c0, c1, c2, o0, o1, o2;
  logic [15:0] s0, s1;
  logic [63:0] s2;
  logic [65:0] q0[$], q1[$], q2[$];

  bsg_adder_ripple_carry_pipelined #(.width_p(16), .stages_p(1)) u0 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(sv), .ready_o(rdy0), .a_i(ra[15:0]), .b_i(rb[15:0]),
    .c_i(rc), .sub_i(rsub), .v_o(v0), .yumi_i(v0), .s_o(s0), .c_o(c0), .ovf_o(o0));
  bsg_adder_ripple_carry_pipelined #(.width_p(16), .stages_p(16)) u1 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(sv), .ready_o(rdy1), .a_i(ra[15:0]), .b_i(rb[15:0]),
    .c_i(rc), .sub_i(rsub), .v_o(v1), .yumi_i(v1), .s_o(s1), .c_o(c1), .ovf_o(o1));
  bsg_adder_ripple_carry_pipelined #(.width_p(64), .stages_p(8)) u2 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(sv), .ready_o(rdy2), .a_i(ra), .b_i(rb),
    .c_i(rc), .sub_i(rsub), .v_o(v2), .yumi_i(v2), .s_o(s2), .c_o(c2), .ovf_o(o2));

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] gold(input int w, input logic [63:0] a, input logic [63:0] b,
                                       input logic c, input logic sub);
    logic [65:0] m, aa, bb, f;
    logic [63:0] s;
    logic ov;
    m  = (66'd1 << w) - 66'd1;
    aa = {2'b0, a} & m;
    bb = (sub ? ~{2'b0, b} : {2'b0, b}) & m;
    f  = aa + bb + {65'd0, c ^ sub};
    s  = f[63:0] & m[63:0];
    ov = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {ov, f[w], s};
  endfunction

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic sub, input logic [31:0] es, input logic ec, input logic eo);
    @(posedge clk); #1;
    a_i = a; b_i = b; c_i = c; sub_i = sub; v_i = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk({tag, "_early"}, {65'd0, v_o}, 66'd0);
    @(posedge clk); #1;
    chk({tag, "_v"}, {65'd0, v_o}, 66'd1);
    chk({tag, "_s"}, {34'd0, s_o}, {34'd0, es});
    chk({tag, "_c"}, {65'd0, c_o}, {65'd0, ec});
    chk({tag, "_ovf"}, {65'd0, ovf}, {65'd0, eo});
  endtask

  initial begin
    int idx, exp_idx;
    reset_n = 1'b0; v_i = 1'b0; yumi_en = 1'b1; a_i = '0; b_i = '0; c_i = 1'b0; sub_i = 1'b0;
    ra = '0; rb = '0; rc = 1'b0; rsub = 1'b0; sv = 1'b0;
    #12;
    chk("rst_v", {65'd0, v_o}, 66'd0);
    chk("rst_s", {34'd0, s_o}, 66'd0);
    chk("rst_c", {65'd0, c_o}, 66'd0);
    chk("rst_ovf", {65'd0, ovf}, 66'd0);
    chk("rst_ready", {65'd0, ready}, 66'd1);
    #10 reset_n = 1'b1;
    run_vec("add_1_2", 32'h1, 32'h2, 1'b0, 1'b0, 32'h3, 1'b0, 1'b0);
    run_vec("ripple_all", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    run_vec("pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_vec("sub_5_7", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_vec("sub_min", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_vec("sub_brw", 32'hA, 32'h3, 1'b1, 1'b1, 32'h6, 1'b1, 1'b0);
    run_vec("seg_carry", 32'h00FF_FF00, 32'h0000_0100, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("drained", {65'd0, v_o}, 66'd0);
    // streaming: 8 inputs, consumer stalls in cycles 6..9
    idx = 0; exp_idx = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      yumi_en = !(n >= 6 && n <= 9);
      v_i = idx < 8; a_i = idx; b_i = 100 * idx; c_i = 1'b0; sub_i = 1'b0;
      #1;
      chk("st_ready", {65'd0, ready}, {65'd0, !(v_o && !yumi_en)});
      if (n == 7) chk("st_stall", {65'd0, ready}, 66'd0);
      if (v_o && !yumi_en) chk("st_hold", {34'd0, s_o}, 66'(101 * exp_idx));
      if (v_o && yumi_en) begin
        chk("st_s", {34'd0, s_o}, 66'(101 * exp_idx));
        exp_idx++;
      end
      if (v_i && ready) idx++;
    end
    v_i = 1'b0;
    chk("st_sent", 66'(idx), 66'd8);
    chk("st_recv", 66'(exp_idx), 66'd8);
    // asynchronous reset while results are in flight
    yumi_en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      v_i = 1'b1; a_i = 32'h10 + n; b_i = 32'h1;
    end
    @(posedge clk); #1;
    v_i = 1'b0;
    for (int n = 0; n < 10 && !v_o; n++) begin
      @(posedge clk); #1;
    end
    chk("mid_v_pre", {65'd0, v_o}, 66'd1);
    chk("mid_s_pre", {34'd0, s_o}, 66'h11);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_v_rst", {65'd0, v_o}, 66'd0);
    chk("mid_s_rst", {34'd0, s_o}, 66'd0);
    chk("mid_ready", {65'd0, ready}, 66'd1);
    #7 reset_n = 1'b1;
    yumi_en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      chk("mid_stale", {65'd0, v_o}, 66'd0);
    end
    // parameter sweep against a golden model
    for (int n = 0; n < 10020; n++) begin
      @(posedge clk); #1;
      if (v0) begin
        if (q0.size() == 0) chk("sw16x1_extra", 66'd1, 66'd0);
        else chk("sw16x1", {o0, c0, 48'd0, s0}, q0.pop_front());
      end
      if (v1) begin
        if (q1.size() == 0) chk("sw16x16_extra", 66'd1, 66'd0);
        else chk("sw16x16", {o1, c1, 48'd0, s1}, q1.pop_front());
      end
      if (v2) begin
        if (q2.size() == 0) chk("sw64x8_extra", 66'd1, 66'd0);
        else chk("sw64x8", {o2, c2, s2}, q2.pop_front());
      end
      sv = n < 10000;
      if (sv) begin
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        rc = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
        if (n < 4) begin
          ra = (n[0]) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
          rb = n[1] ? 64'h1 : 64'h0;
        end
        q0.push_back(gold(16, ra, rb, rc, rsub));
        q1.push_back(gold(16, ra, rb, rc, rsub));
        q2.push_back(gold(64, ra, rb, rc, rsub));
      end
    end
    chk("sw_drain", 66'(q0.size() + q1.size() + q2.size()), 66'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
